// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port synchronous memory.
// Optional fetch starvation guard enabled by defining MEM_ARBITER_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // state | meaning
    // NONE  | no read outstanding, memory read data is ignored
    // IF_RD | fetch read issued last cycle, mem_rdata belongs to fetch port
    // D_RD  | data read issued last cycle, mem_rdata belongs to data port
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        IF_RD = 2'd1,
        D_RD  = 2'd2
    } rd_state_t;

    rd_state_t state, state_nxt;
    logic      fetch_win;

    // Out-of-range limits leave an empty marker block in the elaborated hierarchy.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_out_of_range
    end

`ifdef MEM_ARBITER_STARVE_GUARD_EN
    logic [3:0] starve_cnt, starve_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!if_req || if_gnt) begin
            starve_cnt_nxt = 4'd0;
        end else if (d_gnt && starve_cnt != 4'hF) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
        end
    end

    assign fetch_win = if_req && (!d_req || starve_cnt == 4'(STARVE_LIMIT));
`else
    assign fetch_win = if_req && !d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NONE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are gated by rst_n so every output drops the moment reset asserts.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        state_nxt = NONE;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;

        if (rst_n) begin
            if (fetch_win) begin
                if_gnt    = 1'b1;
                mem_ce    = 1'b1;
                mem_addr  = if_addr;
                state_nxt = IF_RD;
            end else if (d_req) begin
                d_gnt     = 1'b1;
                mem_ce    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                state_nxt = d_we ? NONE : D_RD;
            end
        end

        case (state)
            IF_RD: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            D_RD: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter; expectations come from a cycle-level
// reference model of the arbitration rules. Honours MEM_ARBITER_STARVE_GUARD_EN.
module tb_mem_arbiter;
    localparam int AW  = 11;
    localparam int LIM = 4;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    int total = 0;
    int bad   = 0;

    // reference model: owner 0=none 1=fetch 2=data; waited = data grants while fetch waits
    int owner = 0, owner_nxt = 0, waited = 0, waited_nxt = 0;
    bit            e_if_gnt, e_d_gnt, e_ce, e_we, e_if_rv, e_d_rv;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata, e_if_rd, e_d_rd;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic cyc(input bit ir, input logic [AW-1:0] ia, input bit dr,
                       input bit dwe, input logic [AW-1:0] da, input logic [31:0] dwd);
        bit fetch;
        @(negedge clk);
        owner  = owner_nxt;
        waited = waited_nxt;
        if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        mem_rdata = $urandom;
        fetch    = ir && (!dr || (GUARD && waited == LIM));
        e_if_gnt = fetch;
        e_d_gnt  = dr && !fetch;
        e_ce     = e_if_gnt || e_d_gnt;
        e_we     = e_d_gnt && dwe;
        e_addr   = fetch ? ia : (e_d_gnt ? da : '0);
        e_wdata  = dwd;
        e_if_rv  = (owner == 1);
        e_d_rv   = (owner == 2);
        e_if_rd  = (owner == 1) ? mem_rdata : 32'd0;
        e_d_rd   = (owner == 2) ? mem_rdata : 32'd0;
        owner_nxt  = fetch ? 1 : ((e_d_gnt && !dwe) ? 2 : 0);
        waited_nxt = (!ir || fetch) ? 0 : (e_d_gnt ? waited + 1 : waited);
        #1;
    endtask

    task automatic test_reset();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 11'h3A; d_wdata = 32'hDEAD;
        mem_rdata = 32'hFFFF_FFFF;
        #12;
        total++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_ce, mem_we} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b ce=%b we=%b addr=%h wd=%h rd=%h/%h, need all 0",
                     if_gnt, d_gnt, if_rvalid, d_rvalid, mem_ce, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1; owner_nxt = 0; waited_nxt = 0;
        cyc(1, 11'h010, 0, 0, '0, '0);
        total++;
        if (if_gnt !== 1'b1 || mem_ce !== 1'b1) begin
            bad++;
            $display("FAIL first_grant_after_reset: if_gnt=%b mem_ce=%b need 1 1", if_gnt, mem_ce);
        end
    endtask

    task automatic test_fetch_read();
        cyc(0, '0, 0, 0, '0, '0);
        cyc(1, 11'h005, 0, 0, '0, '0);
        total++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_ce !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 11'h005) begin
            bad++;
            $display("FAIL fetch_grant: if_gnt=%b d_gnt=%b ce=%b we=%b addr=%h need 1 0 1 0 005",
                     if_gnt, d_gnt, mem_ce, mem_we, mem_addr);
        end
        cyc(0, '0, 0, 0, '0, '0);
        mem_rdata = 32'h00C00193;
        #1;
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h00C00193 || d_rvalid !== 1'b0 || d_rdata !== 32'd0) begin
            bad++;
            $display("FAIL fetch_rdata: if_rvalid=%b if_rdata=%h d_rvalid=%b d_rdata=%h need 1 00c00193 0 0",
                     if_rvalid, if_rdata, d_rvalid, d_rdata);
        end
    endtask

    task automatic test_write();
        cyc(0, '0, 1, 1, 11'h000, 32'd7);
        total++;
        if (d_gnt !== 1'b1 || mem_ce !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'h000 || mem_wdata !== 32'd7) begin
            bad++;
            $display("FAIL write_issue: d_gnt=%b ce=%b we=%b addr=%h wdata=%h need 1 1 1 000 7",
                     d_gnt, mem_ce, mem_we, mem_addr, mem_wdata);
        end
        cyc(0, '0, 0, 0, '0, '0);
        total++;
        if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL write_no_rvalid: d_rvalid=%b if_rvalid=%b need 0 0", d_rvalid, if_rvalid);
        end
    endtask

    task automatic test_starve();
        bit exp_if;
        cyc(0, '0, 0, 0, '0, '0);
        for (int k = 0; k < 6; k++) begin
            cyc(1, 11'h100 + AW'(k), 1, 0, 11'h200 + AW'(k), '0);
            exp_if = GUARD && (k == 4);
            total++;
            if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
                bad++;
                $display("FAIL starve_cycle%0d: if_gnt=%b d_gnt=%b need %b %b", k, if_gnt, d_gnt, exp_if, !exp_if);
            end
        end
        cyc(0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_alternate();
        for (int k = 0; k < 7; k++) begin
            if (k == 6) cyc(0, '0, 0, 0, '0, '0);
            else if (k % 2 == 0) cyc(1, AW'($urandom), 0, 0, '0, '0);
            else cyc(0, '0, 1, 0, AW'($urandom), '0);
            total++;
            if (if_rvalid !== e_if_rv || d_rvalid !== e_d_rv || if_rdata !== e_if_rd || d_rdata !== e_d_rd) begin
                bad++;
                $display("FAIL alternate_cycle%0d: rv=%b%b rd=%h/%h need rv=%b%b rd=%h/%h", k, if_rvalid, d_rvalid,
                         if_rdata, d_rdata, e_if_rv, e_d_rv, e_if_rd, e_d_rd);
            end
            total++;
            if (k < 6 && (if_gnt !== (k % 2 == 0) || d_gnt !== (k % 2 == 1))) begin
                bad++;
                $display("FAIL alternate_grant%0d: gnt=%b%b", k, if_gnt, d_gnt);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 3) != 0, AW'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, AW'($urandom), $urandom);
            total++;
            if ({if_gnt, d_gnt, mem_ce, mem_we} !== {e_if_gnt, e_d_gnt, e_ce, e_we}) begin
                bad++;
                $display("FAIL rand_grant@%0d: gnt/ce/we=%b%b%b%b need %b%b%b%b", n, if_gnt, d_gnt, mem_ce, mem_we,
                         e_if_gnt, e_d_gnt, e_ce, e_we);
            end
            total++;
            if ((e_ce && mem_addr !== e_addr) || (e_we && mem_wdata !== e_wdata)) begin
                bad++;
                $display("FAIL rand_bus@%0d: addr=%h wdata=%h need %h %h", n, mem_addr, mem_wdata, e_addr, e_wdata);
            end
            total++;
            if (if_rvalid !== e_if_rv || d_rvalid !== e_d_rv || if_rdata !== e_if_rd || d_rdata !== e_d_rd) begin
                bad++;
                $display("FAIL rand_resp@%0d: rv=%b%b rd=%h/%h need %b%b %h/%h", n, if_rvalid, d_rvalid,
                         if_rdata, d_rdata, e_if_rv, e_d_rv, e_if_rd, e_d_rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, '0, 0, 0, '0, '0);
        cyc(0, '0, 1, 0, 11'h055, '0);
        total++;
        if (d_gnt !== 1'b1) begin
            bad++;
            $display("FAIL midreset_grant: d_gnt=%b need 1", d_gnt);
        end
        if_req = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_ce, mem_we} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: gnt=%b%b rv=%b%b ce=%b we=%b addr=%h rd=%h/%h need all 0",
                     if_gnt, d_gnt, if_rvalid, d_rvalid, mem_ce, mem_we, mem_addr, if_rdata, d_rdata);
        end
        if_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1; owner_nxt = 0; waited_nxt = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(0, '0, 0, 0, '0, '0);
            total++;
            if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL midreset_no_rvalid%0d: d_rvalid=%b if_rvalid=%b need 0 0", k, d_rvalid, if_rvalid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_write();
        test_starve();
        test_alternate();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
